// File: rtl/ahb_arb_pkg.sv
// Shared encodings and helpers for the round-robin AHB bus arbiter.
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   localparam logic [1:0] HRESP_OKAY  = 2'd0;
   localparam logic [1:0] HRESP_ERROR = 2'd1;

   typedef enum logic [1:0] {ARB, FIXED, OPEN} arb_state_t;

   // 0 means undefined length (INCR)
   function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
      case (hburst)
         HBURST_SINGLE:               return 5'd1;
         HBURST_INCR:                 return 5'd0;
         HBURST_WRAP4, HBURST_INCR4:  return 5'd4;
         HBURST_WRAP8, HBURST_INCR8:  return 5'd8;
         default:                     return 5'd16;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: searches from last_i+1 with wrap, so the
// last owner is considered only after everyone else.
module ahb_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   logic [IW-1:0] k;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      k     = '0;
      for (int i = 1; i <= N; i++) begin
         k = IW'((int'(last_i) + i) % N);
         if (!vld_o && req_i[k]) begin
            vld_o    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = k;
         end
      end
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: tracks shared-bus bursts to decide when ownership
// may move, drives registered one-hot HGRANT and the lagging HMASTER select.
//
// state | meaning
// ARB   | no burst open; every ready cycle is an arbitration window
// FIXED | counted burst in flight, beats_q beats still to come
// OPEN  | undefined-length INCR, incr_q beats seen (saturating)
module ahb_bus_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_INCR_BEATS = 16
) (
   input  logic                           CLK,
   input  logic                           HRESETn,
   input  logic [NUM_MASTERS-1:0]         HBUSREQ,
   input  logic [1:0]                     HTRANS,
   input  logic [2:0]                     HBURST,
   input  logic                           HREADY_IN,
   input  logic [1:0]                     HRESP,
   output logic [NUM_MASTERS-1:0]         HGRANT,
   output logic [$clog2(NUM_MASTERS)-1:0] HMASTER
);

   localparam int MW = $clog2(NUM_MASTERS);
   localparam int CW = $clog2(MAX_INCR_BEATS + 1);
   localparam logic [NUM_MASTERS-1:0] PARK_GNT =
      {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
   localparam logic [MW-1:0] PARK_IDX = MW'(DEFAULT_MASTER);
   localparam logic [CW-1:0] INCR_MAX = CW'(MAX_INCR_BEATS);

   arb_state_t             state_q, state_d, ld_state;
   logic [3:0]             beats_q, beats_d, ld_beats;
   logic [CW-1:0]          incr_q, incr_d, ld_incr, incr_nxt;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d, pk_gnt, own_mask;
   logic [MW-1:0]          mst_q, mst_d, pk_idx, gnt_idx;
   logic [4:0]             blen;
   logic                   pk_vld, is_idle, is_nonseq, is_seq, acc;
   logic                   owner_req, others, win;

   ahb_rr_pick #(.N(NUM_MASTERS), .IW(MW)) u_pick (
      .req_i  (HBUSREQ),
      .last_i (mst_q),
      .gnt_o  (pk_gnt),
      .idx_o  (pk_idx),
      .vld_o  (pk_vld)
   );

   assign is_idle   = (HTRANS == HTRANS_IDLE);
   assign is_nonseq = (HTRANS == HTRANS_NONSEQ);
   assign is_seq    = (HTRANS == HTRANS_SEQ);
   assign acc       = HREADY_IN && (is_nonseq || is_seq);
   assign owner_req = HBUSREQ[mst_q];
   assign others    = |(HBUSREQ & ~own_mask);
   assign incr_nxt  = (acc && is_seq && incr_q != INCR_MAX) ? incr_q + CW'(1) : incr_q;

   always_comb begin
      own_mask        = '0;
      own_mask[mst_q] = 1'b1;
      gnt_idx         = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (gnt_q[i]) gnt_idx = MW'(i);
   end

   // Where a fresh NONSEQ would take the tracker
   always_comb begin
      blen     = burst_beats(HBURST);
      ld_state = ARB;
      ld_beats = '0;
      ld_incr  = '0;
      if (blen == 5'd0) begin
         ld_state = OPEN;
         ld_incr  = CW'(1);
      end else if (blen != 5'd1) begin
         ld_state = FIXED;
         ld_beats = 4'(blen - 5'd1);
      end
   end

   always_comb begin
      state_d = state_q;
      beats_d = beats_q;
      incr_d  = incr_q;
      if (HRESP == HRESP_ERROR && !HREADY_IN) begin
         state_d = ARB;
         beats_d = '0;
         incr_d  = '0;
      end else begin
         case (state_q)
            ARB: if (acc && is_nonseq) begin
               state_d = ld_state; beats_d = ld_beats; incr_d = ld_incr;
            end
            FIXED: begin
               if (HREADY_IN && is_idle) begin
                  state_d = ARB; beats_d = '0;
               end else if (acc && is_nonseq) begin
                  state_d = ld_state; beats_d = ld_beats; incr_d = ld_incr;
               end else if (acc && is_seq) begin
                  beats_d = beats_q - 4'd1;
                  if (beats_q == 4'd1) state_d = ARB;
               end
            end
            OPEN: begin
               if ((HREADY_IN && is_idle) || !owner_req ||
                   (HREADY_IN && others && incr_nxt == INCR_MAX)) begin
                  state_d = ARB; incr_d = '0;
               end else if (acc && is_nonseq) begin
                  state_d = ld_state; beats_d = ld_beats; incr_d = ld_incr;
               end else begin
                  incr_d = incr_nxt;
               end
            end
            default: state_d = ARB;
         endcase
      end
   end

   // A last FIXED beat also lands in ARB, so one test covers both window kinds
   assign win   = HREADY_IN && (state_d == ARB);
   assign gnt_d = win ? (pk_vld ? pk_gnt : PARK_GNT) : gnt_q;
   assign mst_d = HREADY_IN ? gnt_idx : mst_q;

   always_ff @(posedge CLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ARB;
         beats_q <= '0;
         incr_q  <= '0;
         gnt_q   <= PARK_GNT;
         mst_q   <= PARK_IDX;
      end else begin
         state_q <= state_d;
         beats_q <= beats_d;
         incr_q  <= incr_d;
         gnt_q   <= gnt_d;
         mst_q   <= mst_d;
      end
   end

   assign HGRANT  = gnt_q;
   assign HMASTER = mst_q;

   a_grant_onehot: assert property (@(posedge CLK) disable iff (!HRESETn) $onehot(gnt_q));

   logic unused_pk;
   assign unused_pk = ^pk_idx;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: stimulus pushes hand-computed grant and
// master expectations, a negedge monitor pops and compares them.
module tb_ahb_bus_arbiter;

   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;
   localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3,
                          B_WRAP8 = 3'd4, B_INCR16 = 3'd7;
   localparam logic [1:0] OK = 2'd0, ERR = 2'd1;

   logic       CLK = 1'b0;
   logic       HRESETn;
   logic [3:0] HBUSREQ = '0;
   logic [1:0] HTRANS = IDLE;
   logic [2:0] HBURST = B_SINGLE;
   logic       HREADY_IN = 1'b1;
   logic [1:0] HRESP = OK;
   logic [3:0] HGRANT;
   logic [1:0] HMASTER;

   int checks = 0;
   int failures = 0;

   logic [3:0] exp_g_q[$];
   logic [1:0] exp_m_q[$];
   string      exp_n_q[$];

   always #5 CLK = ~CLK;

   ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .MAX_INCR_BEATS(16)) dut (
      .CLK       (CLK),
      .HRESETn   (HRESETn),
      .HBUSREQ   (HBUSREQ),
      .HTRANS    (HTRANS),
      .HBURST    (HBURST),
      .HREADY_IN (HREADY_IN),
      .HRESP     (HRESP),
      .HGRANT    (HGRANT),
      .HMASTER   (HMASTER)
   );

   task automatic check(input string nm, input logic [3:0] g, input logic [1:0] m);
      checks++;
      if (HGRANT !== g) begin
         failures++;
         $display("FAIL %s HGRANT got %b want %b", nm, HGRANT, g);
      end
      checks++;
      if (HMASTER !== m) begin
         failures++;
         $display("FAIL %s HMASTER got %0d want %0d", nm, HMASTER, m);
      end
   endtask

   // One bus cycle; expectation describes outputs after the coming edge
   task automatic cyc(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                      input logic rdy, input logic [1:0] rsp,
                      input logic [3:0] eg, input logic [1:0] em, input string nm);
      HBUSREQ = req; HTRANS = tr; HBURST = bu; HREADY_IN = rdy; HRESP = rsp;
      exp_g_q.push_back(eg);
      exp_m_q.push_back(em);
      exp_n_q.push_back(nm);
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (exp_g_q.size() > 0) begin
         logic [3:0] g;
         logic [1:0] m;
         string      nm;
         g  = exp_g_q.pop_front();
         m  = exp_m_q.pop_front();
         nm = exp_n_q.pop_front();
         check(nm, g, m);
      end
   end

   initial begin
      HRESETn = 1'b1;
      #1 HRESETn = 1'b0;
      #1 check("reset", 4'b0001, 2'd0);
      repeat (2) @(negedge CLK);
      #1 HRESETn = 1'b1;

      repeat (6) cyc(4'b0000, IDLE, B_SINGLE, 1, OK, 4'b0001, 2'd0, "park");

      // M1 INCR4 with two wait states on beat 2, M2 waiting
      cyc(4'b0110, IDLE, B_SINGLE, 1, OK, 4'b0010, 2'd0, "incr4_grant");
      cyc(4'b0110, IDLE, B_SINGLE, 1, OK, 4'b0010, 2'd1, "incr4_handover");
      cyc(4'b0110, NSEQ, B_INCR4, 1, OK, 4'b0010, 2'd1, "incr4_b1");
      cyc(4'b1110, SEQ,  B_INCR4, 0, OK, 4'b0010, 2'd1, "incr4_wait1");
      cyc(4'b1100, SEQ,  B_INCR4, 0, OK, 4'b0010, 2'd1, "incr4_wait2");
      cyc(4'b0110, SEQ,  B_INCR4, 1, OK, 4'b0010, 2'd1, "incr4_b2");
      cyc(4'b0110, SEQ,  B_INCR4, 1, OK, 4'b0010, 2'd1, "incr4_b3");
      cyc(4'b0110, SEQ,  B_INCR4, 1, OK, 4'b0100, 2'd1, "incr4_last");
      cyc(4'b0110, IDLE, B_SINGLE, 1, OK, 4'b0100, 2'd2, "incr4_m2");

      // Back to park, then round-robin over SINGLE transfers
      cyc(4'b0000, IDLE, B_SINGLE, 1, OK, 4'b0001, 2'd2, "repark");
      cyc(4'b0000, IDLE, B_SINGLE, 1, OK, 4'b0001, 2'd0, "repark_m");
      for (int i = 0; i < 5; i++) begin
         cyc(4'b1111, (i == 0) ? IDLE : NSEQ, B_SINGLE, 1, OK,
             4'b0001 << ((i + 1) % 4), 2'((i) % 4), "rr_grant");
         cyc(4'b1111, IDLE, B_SINGLE, 1, OK,
             4'b0001 << ((i + 1) % 4), 2'((i + 1) % 4), "rr_master");
      end

      // M3 undefined INCR, M0 waiting: forced handover after 16 beats
      cyc(4'b1000, IDLE, B_SINGLE, 1, OK, 4'b1000, 2'd1, "incr_grant");
      cyc(4'b1000, IDLE, B_SINGLE, 1, OK, 4'b1000, 2'd3, "incr_handover");
      cyc(4'b1000, NSEQ, B_INCR, 1, OK, 4'b1000, 2'd3, "incr_b1");
      repeat (14) cyc(4'b1001, SEQ, B_INCR, 1, OK, 4'b1000, 2'd3, "incr_mid");
      cyc(4'b1001, SEQ,  B_INCR, 1, OK, 4'b0001, 2'd3, "incr_b16_force");
      cyc(4'b1001, IDLE, B_INCR, 1, OK, 4'b0001, 2'd0, "incr_m0");

      // M3 alone keeps an INCR beyond 16 beats
      cyc(4'b1000, IDLE, B_SINGLE, 1, OK, 4'b1000, 2'd0, "solo_grant");
      cyc(4'b1000, IDLE, B_SINGLE, 1, OK, 4'b1000, 2'd3, "solo_handover");
      cyc(4'b1000, NSEQ, B_INCR, 1, OK, 4'b1000, 2'd3, "solo_b1");
      repeat (19) cyc(4'b1000, SEQ, B_INCR, 1, OK, 4'b1000, 2'd3, "solo_long");
      cyc(4'b1000, IDLE, B_INCR, 1, OK, 4'b1000, 2'd3, "solo_end");

      // M2 WRAP8 aborted by ERROR at beat 3, M1 waiting
      cyc(4'b0100, IDLE, B_SINGLE, 1, OK, 4'b0100, 2'd3, "err_grant");
      cyc(4'b0100, IDLE, B_SINGLE, 1, OK, 4'b0100, 2'd2, "err_handover");
      cyc(4'b0110, NSEQ, B_WRAP8, 1, OK, 4'b0100, 2'd2, "err_b1");
      cyc(4'b0110, SEQ,  B_WRAP8, 1, OK, 4'b0100, 2'd2, "err_b2");
      cyc(4'b0110, SEQ,  B_WRAP8, 1, OK, 4'b0100, 2'd2, "err_b3");
      cyc(4'b0110, SEQ,  B_WRAP8, 0, ERR, 4'b0100, 2'd2, "err_first");
      cyc(4'b0110, SEQ,  B_WRAP8, 1, ERR, 4'b0010, 2'd2, "err_ready");
      cyc(4'b0110, IDLE, B_SINGLE, 1, OK, 4'b0010, 2'd1, "err_m1");

      // M1 INCR16, reset with 9 beats left
      cyc(4'b0010, NSEQ, B_INCR16, 1, OK, 4'b0010, 2'd1, "i16_b1");
      repeat (6) cyc(4'b0010, SEQ, B_INCR16, 1, OK, 4'b0010, 2'd1, "i16_mid");
      @(negedge CLK);
      #1 HRESETn = 1'b0;
      #1 check("reset_mid_burst", 4'b0001, 2'd0);
      HBUSREQ = 4'b0001; HTRANS = IDLE; HBURST = B_SINGLE; HREADY_IN = 1'b1; HRESP = OK;
      repeat (2) @(negedge CLK);
      #1 HRESETn = 1'b1;

      // First NONSEQ after reset is tracked from ARB
      cyc(4'b0011, NSEQ, B_INCR4, 1, OK, 4'b0001, 2'd0, "post_b1");
      cyc(4'b0011, SEQ,  B_INCR4, 1, OK, 4'b0001, 2'd0, "post_b2");
      cyc(4'b0011, SEQ,  B_INCR4, 1, OK, 4'b0001, 2'd0, "post_b3");
      cyc(4'b0011, SEQ,  B_INCR4, 1, OK, 4'b0010, 2'd0, "post_last");
      cyc(4'b0011, IDLE, B_SINGLE, 1, OK, 4'b0010, 2'd1, "post_m1");

      repeat (2) @(negedge CLK);
      #1;
      checks++;
      if (exp_g_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending %0d want 0", exp_g_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
